// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 sensor emulator: answers a trig pulse with an echo whose width encodes target_mm.
module ultrasonic_echo_emulator #(
  parameter int unsigned MIN_TRIG_US  = 10,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned MAX_RANGE_MM = 4000,
  parameter int unsigned TIMEOUT_US   = 38000,
  parameter int unsigned HOLDOFF_US   = 100
) (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        trig,
  input  logic [11:0] target_mm,
  input  logic        no_object,
  output logic        echo,
  output logic        busy,
  output logic        trig_short,
  output logic [7:0]  echo_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HCNT_W = 8;
  localparam int unsigned PROD_W = 22;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_BURST   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   w_q, w_d;
  logic               sync1_q, trig_s;
  logic               echo_d, busy_d, short_d;
  logic [7:0]         count_d;
  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  quot;
  logic [CNT_W-1:0]   w_calc;

  // Two-flop synchronizer for the asynchronous trig pin
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      trig_s  <= 1'b0;
    end else begin
      sync1_q <= trig;
      trig_s  <= sync1_q;
    end
  end

  // Echo width: ceiling of target*1000/170 so the driver's floor conversion reads back target
  always_comb begin
    prod = PROD_W'(target_mm) * PROD_W'(1000) + PROD_W'(169);
    quot = prod / PROD_W'(170);
    if (no_object || (32'(target_mm) > MAX_RANGE_MM)) begin
      w_calc = CNT_W'(TIMEOUT_US);
    end else if (quot == '0) begin
      w_calc = CNT_W'(1);
    end else begin
      w_calc = CNT_W'(quot);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      w_q        <= '0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      trig_short <= 1'b0;
      echo_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      w_q        <= w_d;
      echo       <= echo_d;
      busy       <= busy_d;
      trig_short <= short_d;
      echo_count <= count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    w_d     = w_q;
    echo_d  = echo;
    short_d = 1'b0;
    count_d = echo_count;

    case (state_q)
      S_IDLE: begin
        echo_d = 1'b0;
        if (trig_s) begin
          state_d = S_TRIG_HI;
          hcnt_d  = HCNT_W'(1);
        end
      end

      S_TRIG_HI: begin
        if (trig_s) begin
          if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
        end else if (32'(hcnt_q) >= MIN_TRIG_US) begin
          // Width is frozen here; later target_mm changes do not affect this echo
          w_d     = w_calc;
          cnt_d   = CNT_W'(BURST_US);
          state_d = S_BURST;
        end else begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_BURST: begin
        if (cnt_q == CNT_W'(1)) begin
          echo_d  = 1'b1;
          cnt_d   = w_q;
          state_d = S_ECHO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_ECHO: begin
        if (cnt_q == CNT_W'(1)) begin
          echo_d  = 1'b0;
          count_d = echo_count + 8'(1);
          cnt_d   = CNT_W'(HOLDOFF_US);
          state_d = S_HOLDOFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HOLDOFF: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        echo_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Bench for ultrasonic_echo_emulator: timestamp reference model plus directed and random trig traffic.
module tb_ultrasonic_echo_emulator;

  logic        clk_1MHz = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [11:0] target_mm = 12'd0;
  logic        no_object = 1'b0;
  logic        echo, busy, trig_short;
  logic [7:0]  echo_count;

  int checks = 0;
  int failures = 0;

  ultrasonic_echo_emulator dut (
    .clk_1MHz   (clk_1MHz),
    .rst        (rst),
    .trig       (trig),
    .target_mm  (target_mm),
    .no_object  (no_object),
    .echo       (echo),
    .busy       (busy),
    .trig_short (trig_short),
    .echo_count (echo_count)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Smallest width whose floor(width*170/1000) reaches the target
  function automatic int w_of(input int tgt, input bit nobj);
    int w;
    if (nobj || tgt > 4000) return 38000;
    w = (tgt * 1000) / 170;
    while ((w * 170) / 1000 < tgt) w++;
    if (w == 0) w = 1;
    return w;
  endfunction

  // Reference model: edge counter t, scheduled echo as absolute edge timestamps
  int t = 0;
  bit m_s1, m_s2, sched, meas;
  int hlen, rise_t, fall_t, idle_t;
  bit exp_echo, exp_busy, exp_short;
  int exp_cnt = 0;

  initial begin
    bit ts;
    int w;
    forever begin
      @(posedge clk_1MHz);
      t++;
      if (rst) begin
        m_s1 = 0; m_s2 = 0; sched = 0; meas = 0;
        exp_echo = 0; exp_busy = 0; exp_short = 0; exp_cnt = 0;
      end else begin
        ts = m_s2;
        m_s2 = m_s1;
        m_s1 = trig;
        exp_short = 0;
        if (sched) begin
          if (t == fall_t) exp_cnt = (exp_cnt + 1) % 256;
          exp_echo = (t >= rise_t) && (t < fall_t);
          exp_busy = (t < idle_t);
          if (t == idle_t) sched = 0;
        end else if (meas) begin
          if (ts) begin
            if (hlen < 255) hlen++;
          end else begin
            meas = 0;
            if (hlen >= 10) begin
              w = w_of(int'(target_mm), no_object);
              rise_t = t + 200;
              fall_t = rise_t + w;
              idle_t = fall_t + 100;
              sched = 1;
              exp_busy = 1;
            end else begin
              exp_short = 1;
              exp_busy = 0;
            end
          end
        end else if (ts) begin
          meas = 1;
          hlen = 1;
          exp_busy = 1;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus echo edge monitor
  bit cmp_en = 0;
  int last_rise = -1;
  int last_width = -1;
  int short_seen = 0;
  bit prev_echo = 0;

  initial begin
    forever begin
      @(negedge clk_1MHz);
      if (cmp_en) begin
        chk("echo", int'(echo), int'(exp_echo));
        chk("busy", int'(busy), int'(exp_busy));
        chk("trig_short", int'(trig_short), int'(exp_short));
        chk("echo_count", int'(echo_count), exp_cnt);
      end
      if (echo && !prev_echo) last_rise = t;
      if (!echo && prev_echo) last_width = t - last_rise;
      if (trig_short) short_seen++;
      prev_echo = echo;
    end
  end

  task automatic pulse(input int n);
    trig = 1'b1;
    repeat (n) @(negedge clk_1MHz);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk_1MHz);
    while ((sched || meas || busy) && n < budget) begin
      @(negedge clk_1MHz);
      n++;
    end
    chk({name, "_idle_timeout"}, int'(n >= budget), 0);
    repeat (2) @(negedge clk_1MHz);
  endtask

  task automatic wait_echo(input bit v, input int budget, input string name);
    int n = 0;
    while (echo != v && n < budget) begin
      @(negedge clk_1MHz);
      n++;
    end
    chk({name, "_echo_timeout"}, int'(n >= budget), 0);
  endtask

  initial begin
    int k, s0, c0, n;

    // Pin the model against hand-computed widths
    chk("model_w170", w_of(170, 0), 1000);
    chk("model_w1000", w_of(1000, 0), 5883);
    chk("model_w0", w_of(0, 0), 1);
    chk("model_w4000", w_of(4000, 0), 23530);
    chk("model_w4001", w_of(4001, 0), 38000);
    chk("model_wnobj", w_of(5, 1), 38000);
    chk("model_w300", w_of(300, 0), 1765);
    chk("model_w50", w_of(50, 0), 295);

    repeat (2) @(negedge clk_1MHz);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_short", int'(trig_short), 0);
    chk("rst_count", int'(echo_count), 0);
    cmp_en = 1;
    rst = 1'b0;
    repeat (3) @(negedge clk_1MHz);

    // Nominal echo
    target_mm = 12'd170;
    pulse(50);
    k = t + 1;
    wait_idle(3000, "t1");
    chk("t1_rise", last_rise, k + 202);
    chk("t1_width", last_width, 1000);
    chk("t1_count", int'(echo_count), 1);

    // Round trip widths
    target_mm = 12'd1000;
    pulse(20);
    wait_idle(8000, "t2a");
    chk("t2_w1000", last_width, 5883);
    chk("t2_rt1000", (last_width * 170) / 1000, 1000);
    target_mm = 12'd0;
    pulse(20);
    wait_idle(1000, "t2b");
    chk("t2_w0", last_width, 1);
    chk("t2_rt0", (last_width * 170) / 1000, 0);

    // Range limits
    target_mm = 12'd4001;
    pulse(20);
    wait_idle(40000, "t3a");
    chk("t3_w4001", last_width, 38000);
    target_mm = 12'd4000;
    pulse(20);
    wait_idle(25000, "t3b");
    chk("t3_w4000", last_width, 23530);
    chk("t3_rt4000", (last_width * 170) / 1000, 4000);

    // Short trigs and the acceptance boundary
    s0 = short_seen; c0 = int'(echo_count);
    pulse(5);
    wait_idle(100, "t4a");
    chk("t4_short5", short_seen, s0 + 1);
    chk("t4_count5", int'(echo_count), c0);
    chk("t4_busy5", int'(busy), 0);
    pulse(9);
    wait_idle(100, "t4b");
    chk("t4_short9", short_seen, s0 + 2);
    target_mm = 12'd0;
    pulse(10);
    wait_idle(1000, "t4c");
    chk("t4_short10", short_seen, s0 + 2);
    chk("t4_count10", int'(echo_count), c0 + 1);

    // Re-trig during BURST/ECHO/HOLDOFF, target change mid-echo, trig held into IDLE
    c0 = int'(echo_count);
    target_mm = 12'd300;
    pulse(20);
    repeat (50) @(negedge clk_1MHz);
    pulse(15);
    wait_echo(1'b1, 400, "t5a");
    repeat (100) @(negedge clk_1MHz);
    target_mm = 12'd50;
    pulse(15);
    wait_echo(1'b0, 3000, "t5b");
    @(negedge clk_1MHz);
    chk("t5_width_frozen", last_width, 1765);
    repeat (10) @(negedge clk_1MHz);
    pulse(15);
    repeat (15) @(negedge clk_1MHz);
    trig = 1'b1;
    repeat (120) @(negedge clk_1MHz);
    trig = 1'b0;
    wait_idle(1500, "t5c");
    chk("t5_count", int'(echo_count), c0 + 2);
    chk("t5_width2", last_width, 295);

    // Reset mid-echo
    no_object = 1'b1;
    target_mm = 12'd100;
    pulse(20);
    wait_echo(1'b1, 400, "t6a");
    repeat (100) @(negedge clk_1MHz);
    #1 rst = 1'b1;
    #1;
    chk("t6_echo_drop", int'(echo), 0);
    chk("t6_busy_drop", int'(busy), 0);
    chk("t6_count_clr", int'(echo_count), 0);
    @(negedge clk_1MHz);
    repeat (2) @(negedge clk_1MHz);
    rst = 1'b0;
    no_object = 1'b0;
    target_mm = 12'd170;
    repeat (3) @(negedge clk_1MHz);
    pulse(20);
    k = t + 1;
    wait_idle(3000, "t6b");
    chk("t6_rise", last_rise, k + 202);
    chk("t6_width", last_width, 1000);
    chk("t6_count", int'(echo_count), 1);

    // Random trig traffic against the model
    for (int it = 0; it < 6; it++) begin
      target_mm = 12'($urandom_range(0, 60));
      n = $urandom_range(200, 500);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 19) == 0) trig = ~trig;
        if ($urandom_range(0, 99) == 0) target_mm = 12'($urandom_range(0, 60));
        @(negedge clk_1MHz);
      end
      trig = 1'b0;
      wait_idle(3000, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_emulator.md
Name: ultrasonic_echo_emulator

Overview:
Synthesizable model of the HC-SR04 sensor, i.e. the responder end of the trig/echo interface. It sits on the sensor side of the pins for hardware-in-loop testing of the ranging driver. It receives `trig`, checks the pulse width, waits a fixed burst delay, then drives `echo` high for a width derived from a programmed target distance in mm. The width is chosen so the driver's conversion `floor(width_us*170/1000)` returns exactly that distance.

Parameters:
- MIN_TRIG_US, 10: minimum accepted trig high time, in clk cycles (1 cycle = 1 µs).
- BURST_US, 200: delay from accepted trig fall to echo rise (emulates the 8x40 kHz burst).
- MAX_RANGE_MM, 4000: largest distance that produces a proportional echo.
- TIMEOUT_US, 38000: echo width when there is no object or the target is out of range.
- HOLDOFF_US, 100: dead time after echo fall, during which trig is ignored.

Ports:
- clk_1MHz  input  1  system clock, 1 MHz.
- rst  input  1  asynchronous, active-high reset.
- trig  input  1  trigger from the ranging driver; asynchronous to the model.
- target_mm  input  12  emulated target distance in mm.
- no_object  input  1  forces a timeout-width echo.
- echo  output  1  echo pulse, registered.
- busy  output  1  high in every state except IDLE.
- trig_short  output  1  one-cycle pulse when a trig is rejected for being too short.
- echo_count  output  8  count of completed echoes; wraps 255 -> 0.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Clock port is `clk_1MHz`, reset port is `rst`.
- Reset values:
  - echo=0, busy=0, trig_short=0, echo_count=0.
  - Both synchronizer flops = 0.
  - All counters = 0; state = IDLE.
  - Reset applied mid-operation (any state) drops echo on the same edge as reset assertion.
- trig passes through a 2-flop synchronizer to give trig_s. All timing below is referenced to trig_s.
- State machine:
  - IDLE: echo=0. When trig_s=1, go to TRIG_HI with hcnt=1.
  - TRIG_HI:
    - While trig_s=1, hcnt increments and saturates at 255.
    - On trig_s=0 with hcnt>=MIN_TRIG_US: latch target_mm and no_object, compute W, go to BURST with cnt=BURST_US.
    - On trig_s=0 with hcnt<MIN_TRIG_US: pulse trig_short for one cycle and return to IDLE.
  - BURST: cnt decrements. On the cycle cnt==1, set echo=1, cnt=W, and go to ECHO. Exactly BURST_US cycles are spent in BURST.
  - ECHO: cnt decrements. On cnt==1, set echo=0, increment echo_count, cnt=HOLDOFF_US, and go to HOLDOFF. echo is high for exactly W cycles.
  - HOLDOFF: cnt decrements, then go to IDLE. If trig is still high on return, IDLE treats it as a new trig and measures its width from that point.
  - Any unused state encoding returns to IDLE.
- Trig activity in BURST, ECHO and HOLDOFF is ignored, with no error pulse.
- Echo width W (16-bit):
  - If latched no_object=1 or target > MAX_RANGE_MM: W = TIMEOUT_US.
  - Otherwise W = (target*1000 + 169) / 170, i.e. the ceiling. Use a 22-bit intermediate and constant division.
  - If the result is 0, W = 1.
- Overall timing: if k is the first edge at which the trig pin is sampled low, echo rises at edge k+2+BURST_US and falls W cycles later.
- target_mm changes after the latch point have no effect on the echo in flight.

Test Plan:
1. Nominal: target=170, 50-cycle trig -> echo rises BURST_US+2 cycles after trig fall, width exactly 1000 cycles; echo_count=1.
2. Round trip: target=1000 -> width 5883. target=0 -> width 1. Each width, converted as width*170/1000, returns the programmed value.
3. Range limits: target=4001 or no_object=1 -> width 38000. target=4000 -> width 23530.
4. Short trig: 5-cycle trig -> one trig_short pulse, echo stays 0, busy returns low, echo_count unchanged.
5. Re-trig: trig pulses during BURST, ECHO and HOLDOFF are ignored; target_mm changed mid-echo leaves the width unchanged. A trig held high into IDLE produces a correctly timed second echo.
6. Reset: rst asserted mid-ECHO -> echo=0 immediately, state IDLE, echo_count=0; a clean echo follows the next valid trig.
